// File: rtl/lms_weight_update_pkg.sv
// ---------------------------------------------------------------------------
// lms_weight_update_pkg : state encoding, defaults and saturating arithmetic
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lms_weight_update_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_QP    = 12;
    localparam int DEF_LEN   = 8;
    // Helpers below work on a common container wide enough for any WIDTH <= MAXW.
    localparam int MAXW      = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCALE  = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic signed [MAXW:0] sat_hi(input int unsigned w);
        logic signed [MAXW:0] one;
        one = (MAXW+1)'(1);
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic logic signed [MAXW:0] sat_lo(input int unsigned w);
        return ~sat_hi(w);
    endfunction

    function automatic logic signed [MAXW-1:0] sat_add(
        input logic signed [MAXW-1:0] a,
        input logic signed [MAXW-1:0] b,
        input int unsigned            w
    );
        logic signed [MAXW:0] s;
        s = (MAXW+1)'(a) + (MAXW+1)'(b);
        if (s > sat_hi(w)) begin
            s = sat_hi(w);
        end else if (s < sat_lo(w)) begin
            s = sat_lo(w);
        end
        return MAXW'(s);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lms_weight_update_fx_mult_sat.sv
// ---------------------------------------------------------------------------
// fx_mult_sat : signed fixed-point multiply, arithmetic >>QP, saturate
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fx_mult_sat
    import lms_weight_update_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int QP    = DEF_QP
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [WIDTH-1:0] p_o
);

    localparam logic signed [2*WIDTH-1:0] HI2 = (2*WIDTH)'(sat_hi(WIDTH));
    localparam logic signed [2*WIDTH-1:0] LO2 = (2*WIDTH)'(sat_lo(WIDTH));

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shifted;

    always_comb begin
        prod    = (2*WIDTH)'(a_i) * (2*WIDTH)'(b_i);
        // Arithmetic shift floors toward -inf, so tiny negatives become -1.
        shifted = prod >>> QP;
        if (shifted > HI2) begin
            p_o = WIDTH'(HI2);
        end else if (shifted < LO2) begin
            p_o = WIDTH'(LO2);
        end else begin
            p_o = WIDTH'(shifted);
        end
    end

endmodule

`default_nettype wire

// File: rtl/lms_weight_update.sv
// ---------------------------------------------------------------------------
// lms_weight_update : serial LMS tap update w[k] += mu*e*x[k], one tap/clock
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lms_weight_update
    import lms_weight_update_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int QP    = DEF_QP,
    parameter int LEN   = DEF_LEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WIDTH-1:0]        err,
    input  logic [WIDTH-1:0]        mu,
    input  logic [LEN*WIDTH-1:0]    x_packed,
    input  logic                    init,
    input  logic [LEN*WIDTH-1:0]    w_init_packed,
    output logic [LEN*WIDTH-1:0]    w_packed,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        k_q, k_d;
    logic signed [WIDTH-1:0] g_q, g_d;
    logic signed [WIDTH-1:0] err_q, mu_q;
    logic signed [WIDTH-1:0] x_q [LEN];
    logic signed [WIDTH-1:0] w_q [LEN];
    logic signed [WIDTH-1:0] w_d [LEN];

    logic signed [WIDTH-1:0] mul_a, mul_b, mul_p;
    logic                    accept;

    assign accept = (state_q == S_IDLE) && start && !init;

    // One multiplier serves both the step scaling and every tap product.
    always_comb begin
        mul_a = g_q;
        mul_b = x_q[k_q];
        if (state_q == S_SCALE) begin
            mul_a = mu_q;
            mul_b = err_q;
        end
    end

    fx_mult_sat #(
        .WIDTH (WIDTH),
        .QP    (QP)
    ) u_mult (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        g_d     = g_q;
        w_d     = w_q;
        case (state_q)
            S_IDLE: begin
                if (init) begin
                    for (int k = 0; k < LEN; k++) begin
                        w_d[k] = w_init_packed[k*WIDTH +: WIDTH];
                    end
                end else if (start) begin
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                g_d     = mul_p;
                k_d     = '0;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                w_d[k_q] = WIDTH'(sat_add(MAXW'(w_q[k_q]), MAXW'(mul_p), WIDTH));
                if (k_q == LAST_IDX) begin
                    k_d     = '0;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            g_q     <= '0;
            err_q   <= '0;
            mu_q    <= '0;
            for (int k = 0; k < LEN; k++) begin
                x_q[k] <= '0;
                w_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            g_q     <= g_d;
            w_q     <= w_d;
            if (accept) begin
                err_q <= err;
                mu_q  <= mu;
                for (int k = 0; k < LEN; k++) begin
                    x_q[k] <= x_packed[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    generate
        for (genvar gk = 0; gk < LEN; gk++) begin : g_pack
            assign w_packed[gk*WIDTH +: WIDTH] = w_q[gk];
        end
    endgenerate

    assign busy = (state_q == S_SCALE) || (state_q == S_UPDATE);
    assign done = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_lms_weight_update.sv
// ---------------------------------------------------------------------------
// tb_lms_weight_update : directed vectors, expected weight banks scoreboarded
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lms_weight_update;

    localparam int W   = 16;
    localparam int LEN = 8;
    localparam int VW  = W * LEN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          init = 1'b0;
    logic [W-1:0]  err = '0;
    logic [W-1:0]  mu = '0;
    logic [VW-1:0] x_packed = '0;
    logic [VW-1:0] w_init_packed = '0;
    logic [VW-1:0] w_packed;
    logic          busy;
    logic          done;

    lms_weight_update #(.WIDTH(W), .QP(12), .LEN(LEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .err           (err),
        .mu            (mu),
        .x_packed      (x_packed),
        .init          (init),
        .w_init_packed (w_init_packed),
        .w_packed      (w_packed),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] w;
        string         nm;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [VW-1:0] fill(input logic [W-1:0] v);
        logic [VW-1:0] r;
        for (int k = 0; k < LEN; k++) r[k*W +: W] = v;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding pass.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_done: got done=1, want no pass outstanding");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk(e.nm, w_packed, e.w);
            end
        end
    end

    task automatic do_init(input logic [VW-1:0] v);
        w_init_packed = v;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        chk("init_load", w_packed, v);
        chk("init_busy", VW'(busy), VW'(1'b0));
    endtask

    // glitch >= 0 pulses start and init at that cycle of the running pass.
    task automatic run_pass(input logic [W-1:0] m, input logic [W-1:0] e,
                            input logic [VW-1:0] x, input logic [VW-1:0] exp_w,
                            input string nm, input int glitch);
        int n;
        mu = m;
        err = e;
        x_packed = x;
        sb_q.push_back('{exp_w, nm});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 30) begin
            if (n == glitch) begin
                start = 1'b1;
                init = 1'b1;
                w_init_packed = ~exp_w;
            end else begin
                start = 1'b0;
                init = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        init = 1'b0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done in 30 cycles, want done", nm);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        logic [VW-1:0] v;

        // 1: reset state and init
        repeat (2) @(negedge clk);
        chk("rst_w", w_packed, '0);
        chk("rst_busy", VW'(busy), VW'(1'b0));
        chk("rst_done", VW'(done), VW'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_w", w_packed, '0);
        do_init(fill(16'd4096));

        // 2: basic pass with per-cycle timing
        mu = 16'd2048;
        err = 16'd4096;
        x_packed = fill(16'd4096);
        sb_q.push_back('{fill(16'd6144), "basic_pass"});
        start = 1'b1;
        for (int j = 0; j <= 9; j++) begin
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < LEN; k++) v[k*W +: W] = (k + 2 <= j) ? 16'd6144 : 16'd4096;
            chk($sformatf("basic_w_T%0d", j + 1), w_packed, v);
            chk($sformatf("basic_busy_T%0d", j + 1), VW'(busy), VW'(j <= 8));
            chk($sformatf("basic_done_T%0d", j + 1), VW'(done), VW'(j == 9));
        end
        @(negedge clk);

        // 3: negative and truncation
        do_init(fill(16'd0));
        run_pass(16'd4096, 16'hF000, fill(16'd2048), fill(16'hF800), "neg_pass", -1);
        do_init(fill(16'd0));
        run_pass(16'd1, 16'd1, fill(16'd2048), fill(16'd0), "g_zero", -1);
        run_pass(16'd1, 16'hFFFF, fill(16'd4096), fill(16'hFFFF), "floor_neg", -1);
        do_init(fill(16'd0));
        for (int k = 0; k < LEN; k++) v[k*W +: W] = 16'(k * 512);
        run_pass(16'd4096, 16'd4096, v, v, "ramp_x", -1);

        // 4: saturation on add and on multiply
        do_init(fill(16'h7FFF));
        run_pass(16'd4096, 16'd4096, fill(16'd4096), fill(16'h7FFF), "sat_pos", -1);
        do_init(fill(16'h8000));
        run_pass(16'd4096, 16'hF000, fill(16'd4096), fill(16'h8000), "sat_neg", -1);
        do_init(fill(16'd0));
        run_pass(16'h7FFF, 16'h7FFF, fill(16'd4096), fill(16'h7FFF), "mult_sat", -1);

        // 5: control conflicts
        do_init(fill(16'd4096));
        run_pass(16'd2048, 16'd4096, fill(16'd4096), fill(16'd6144), "start_mid_pass", 3);
        w_init_packed = fill(16'd1234);
        init = 1'b1;
        start = 1'b1;
        @(negedge clk);
        init = 1'b0;
        start = 1'b0;
        chk("init_start_w", w_packed, fill(16'd1234));
        repeat (3) begin
            @(negedge clk);
            chk("init_start_busy", VW'(busy), VW'(1'b0));
        end

        // 6: reset while tap 3 is updating
        do_init(fill(16'd100));
        mu = 16'd4096;
        err = 16'd4096;
        x_packed = fill(16'd4096);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < LEN; k++) v[k*W +: W] = (k < 3) ? 16'd4196 : 16'd100;
        chk("pre_abort_w", w_packed, v);
        rst_n = 1'b0;
        #1;
        chk("abort_w", w_packed, '0);
        chk("abort_busy", VW'(busy), VW'(1'b0));
        chk("abort_done", VW'(done), VW'(1'b0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_abort_w", w_packed, '0);
        do_init(fill(16'd4096));
        run_pass(16'd2048, 16'd4096, fill(16'd4096), fill(16'd6144), "after_abort_pass", -1);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_done: got %0d passes without done, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
